axi_lsu_slave: RTL and testbench

- AXI4-Lite-style responder (slave) that terminates the LSU master's five channels: AW, W, B, AR and R.
- Backs accesses with a synchronous 64-bit-wide memory array and programmable read latency.
- Used as the simulation and bring-up data memory behind the pipeline's LSU.
- Write and read paths are independent FSMs sharing one storage array.

---
 rtl/axi_lsu_slave_pkg.sv | 29 ++
 rtl/axi_lsu_slave_mem.sv | 32 +++
 rtl/axi_lsu_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_lsu_slave.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lsu_slave_pkg.sv
// Shared widths, response codes and FSM encodings for the LSU-facing AXI-Lite data memory.
// Optional SLVERR range checking is enabled by defining YSYX_22051013_AXI_SLV_ERR_EN.
package axi_lsu_slave_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        StWIdle,
        StWResp
    } wr_state_e;

    typedef enum logic [1:0] {
        StRIdle,
        StRWait,
        StRData
    } rd_state_e;

    // True when the address lies above the implemented array.
    function automatic logic addr_hi_err(input logic [ADDR_W-1:0] addr, input int unsigned idx_w);
        return (addr >> (idx_w + 3)) != '0;
    endfunction

endpackage

// File: rtl/axi_lsu_slave_mem.sv
// Single-clock 64-bit storage array: one byte-masked write port, one asynchronous read port.
// Reads during a same-edge write see the previous contents.
module axi_slv_mem
    import axi_lsu_slave_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_lsu_slave.sv
// AXI4-Lite-style data memory responder for the LSU; independent write and read FSMs.
// Define YSYX_22051013_AXI_SLV_ERR_EN to answer out-of-range addresses with SLVERR.
module axi_lsu_slave
    import axi_lsu_slave_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = 10,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_aw_addr,
    input  logic              i_aw_valid,
    output logic              o_aw_ready,
    input  logic [DATA_W-1:0] i_w_data,
    input  logic [STRB_W-1:0] i_w_strb,
    input  logic              i_w_valid,
    output logic              o_w_ready,
    output logic [RESP_W-1:0] o_b_resp,
    output logic              o_b_valid,
    input  logic              i_b_ready,
    input  logic [ADDR_W-1:0] i_ar_addr,
    input  logic              i_ar_valid,
    output logic              o_ar_ready,
    output logic [DATA_W-1:0] o_r_data,
    output logic [RESP_W-1:0] o_r_resp,
    output logic              o_r_valid,
    input  logic              i_r_ready
);

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT);

    logic w_aw_addr_err;
    logic w_ar_addr_err;

`ifdef YSYX_22051013_AXI_SLV_ERR_EN
    assign w_aw_addr_err = addr_hi_err(i_aw_addr, IDX_W);
    assign w_ar_addr_err = addr_hi_err(i_ar_addr, IDX_W);
`else
    assign w_aw_addr_err = 1'b0;
    assign w_ar_addr_err = 1'b0;
`endif

    logic w_unused_addr;
    assign w_unused_addr = ^{i_aw_addr[2:0], i_ar_addr[2:0],
                             i_aw_addr[ADDR_W-1:IDX_W+3], i_ar_addr[ADDR_W-1:IDX_W+3]};

    // ---------------- write path ----------------
    wr_state_e         r_wr_state;
    logic              r_aw_done, r_w_done, r_aw_err;
    logic [IDX_W-1:0]  r_aw_idx;
    logic [DATA_W-1:0] r_w_data;
    logic [STRB_W-1:0] r_w_strb;
    logic              r_aw_ready, r_w_ready, r_b_valid;
    logic [RESP_W-1:0] r_b_resp;

    logic              w_aw_hs, w_w_hs, w_aw_cap, w_w_cap, w_commit, w_cur_err, w_mem_we;
    logic [IDX_W-1:0]  w_cur_idx;
    logic [DATA_W-1:0] w_cur_data;
    logic [STRB_W-1:0] w_cur_strb;

    assign w_aw_hs  = i_aw_valid & r_aw_ready;
    assign w_w_hs   = i_w_valid & r_w_ready;
    assign w_aw_cap = r_aw_done | w_aw_hs;
    assign w_w_cap  = r_w_done | w_w_hs;
    assign w_commit = (r_wr_state == StWIdle) & w_aw_cap & w_w_cap;

    // A channel arriving on the commit edge bypasses its holding register.
    assign w_cur_idx  = w_aw_hs ? i_aw_addr[IDX_W+2:3] : r_aw_idx;
    assign w_cur_err  = w_aw_hs ? w_aw_addr_err : r_aw_err;
    assign w_cur_data = w_w_hs ? i_w_data : r_w_data;
    assign w_cur_strb = w_w_hs ? i_w_strb : r_w_strb;
    assign w_mem_we   = w_commit & ~w_cur_err;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_state <= StWIdle;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_aw_err   <= 1'b0;
            r_aw_idx   <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
        end else begin
            unique case (r_wr_state)
                StWIdle: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                        r_aw_idx  <= i_aw_addr[IDX_W+2:3];
                        r_aw_err  <= w_aw_addr_err;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                        r_w_data <= i_w_data;
                        r_w_strb <= i_w_strb;
                    end
                    if (w_commit) begin
                        r_wr_state <= StWResp;
                        r_b_valid  <= 1'b1;
                        r_b_resp   <= w_cur_err ? RESP_SLVERR : RESP_OKAY;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b0;
                    end else begin
                        r_aw_ready <= ~w_aw_cap;
                        r_w_ready  <= ~w_w_cap;
                    end
                end
                StWResp: begin
                    if (i_b_ready) begin
                        r_wr_state <= StWIdle;
                        r_b_valid  <= 1'b0;
                        r_b_resp   <= RESP_OKAY;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                    end
                end
                default: r_wr_state <= StWIdle;
            endcase
        end
    end

    // ---------------- read path ----------------
    rd_state_e         r_rd_state;
    logic [IDX_W-1:0]  r_ar_idx;
    logic              r_ar_err;
    logic [3:0]        r_cnt;
    logic              r_ar_ready, r_r_valid;
    logic [DATA_W-1:0] r_r_data;
    logic [RESP_W-1:0] r_r_resp;

    logic              w_ar_hs, w_smp_err;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_mem_rdata, w_smp_data;
    logic [RESP_W-1:0] w_smp_resp;

    assign w_ar_hs    = i_ar_valid & r_ar_ready;
    assign w_rd_idx   = (r_rd_state == StRIdle) ? i_ar_addr[IDX_W+2:3] : r_ar_idx;
    assign w_smp_err  = (r_rd_state == StRIdle) ? w_ar_addr_err : r_ar_err;
    assign w_smp_data = w_smp_err ? '0 : w_mem_rdata;
    assign w_smp_resp = w_smp_err ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_state <= StRIdle;
            r_ar_idx   <= '0;
            r_ar_err   <= 1'b0;
            r_cnt      <= '0;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
        end else begin
            unique case (r_rd_state)
                StRIdle: begin
                    if (w_ar_hs) begin
                        r_ar_ready <= 1'b0;
                        r_ar_idx   <= i_ar_addr[IDX_W+2:3];
                        r_ar_err   <= w_ar_addr_err;
                        if (RD_LAT == 0) begin
                            r_rd_state <= StRData;
                            r_r_valid  <= 1'b1;
                            r_r_data   <= w_smp_data;
                            r_r_resp   <= w_smp_resp;
                        end else begin
                            r_rd_state <= StRWait;
                            r_cnt      <= LAT_LOAD;
                        end
                    end else begin
                        r_ar_ready <= 1'b1;
                    end
                end
                StRWait: begin
                    if (r_cnt == 4'd1) begin
                        r_rd_state <= StRData;
                        r_r_valid  <= 1'b1;
                        r_r_data   <= w_smp_data;
                        r_r_resp   <= w_smp_resp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StRData: begin
                    if (i_r_ready) begin
                        r_rd_state <= StRIdle;
                        r_r_valid  <= 1'b0;
                        r_r_resp   <= RESP_OKAY;
                        r_ar_ready <= 1'b1;
                    end
                end
                default: r_rd_state <= StRIdle;
            endcase
        end
    end

    axi_slv_mem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (w_cur_idx),
        .i_wdata (w_cur_data),
        .i_wstrb (w_cur_strb),
        .i_raddr (w_rd_idx),
        .o_rdata (w_mem_rdata)
    );

    assign o_aw_ready = r_aw_ready;
    assign o_w_ready  = r_w_ready;
    assign o_b_valid  = r_b_valid;
    assign o_b_resp   = r_b_resp;
    assign o_ar_ready = r_ar_ready;
    assign o_r_valid  = r_r_valid;
    assign o_r_data   = r_r_data;
    assign o_r_resp   = r_r_resp;

endmodule

// File: tb/tb_axi_lsu_slave.sv
// Self-checking bench for axi_lsu_slave against a byte-array reference memory.
// Honours YSYX_22051013_AXI_SLV_ERR_EN when computing expected responses.
module tb_axi_lsu_slave;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned IDX_W     = 10;
    localparam int unsigned RD_LAT    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [31:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready = 1'b0;

    always #5 clk = ~clk;

    axi_lsu_slave #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W),
        .RD_LAT    (RD_LAT)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_aw_addr  (aw_addr),
        .i_aw_valid (aw_valid),
        .o_aw_ready (aw_ready),
        .i_w_data   (w_data),
        .i_w_strb   (w_strb),
        .i_w_valid  (w_valid),
        .o_w_ready  (w_ready),
        .o_b_resp   (b_resp),
        .o_b_valid  (b_valid),
        .i_b_ready  (b_ready),
        .i_ar_addr  (ar_addr),
        .i_ar_valid (ar_valid),
        .o_ar_ready (ar_ready),
        .o_r_data   (r_data),
        .o_r_resp   (r_resp),
        .o_r_valid  (r_valid),
        .i_r_ready  (r_ready)
    );

    // Extra instances exercising the latency extremes (RD_LAT 0 and 3).
    logic        l_ar_valid [2];
    logic        l_r_ready  [2];
    logic        l_ar_ready [2];
    logic        l_r_valid  [2];
    logic [63:0] l_r_data   [2];
    logic [1:0]  l_r_resp   [2];
    logic        l_aw_ready [2];
    logic        l_w_ready  [2];
    logic        l_b_valid  [2];
    logic [1:0]  l_b_resp   [2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int unsigned LAT = (g == 0) ? 0 : 3;
        axi_lsu_slave #(
            .MEM_WORDS (MEM_WORDS),
            .IDX_W     (IDX_W),
            .RD_LAT    (LAT)
        ) u_lat (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_aw_addr  (32'h0),
            .i_aw_valid (1'b0),
            .o_aw_ready (l_aw_ready[g]),
            .i_w_data   (64'h0),
            .i_w_strb   (8'h0),
            .i_w_valid  (1'b0),
            .o_w_ready  (l_w_ready[g]),
            .o_b_resp   (l_b_resp[g]),
            .o_b_valid  (l_b_valid[g]),
            .i_b_ready  (1'b0),
            .i_ar_addr  (ar_addr),
            .i_ar_valid (l_ar_valid[g]),
            .o_ar_ready (l_ar_ready[g]),
            .o_r_data   (l_r_data[g]),
            .o_r_resp   (l_r_resp[g]),
            .o_r_valid  (l_r_valid[g]),
            .i_r_ready  (l_r_ready[g])
        );
    end

    // ---------------- reference model ----------------
    logic [63:0] mdl [MEM_WORDS];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [1:0] m_resp(input logic [31:0] a);
`ifdef YSYX_22051013_AXI_SLV_ERR_EN
        return ((a >> (IDX_W + 3)) != 0) ? 2'b10 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 3) % MEM_WORDS);
    endfunction

    function automatic logic [63:0] m_rdata(input logic [31:0] a);
        return (m_resp(a) == 2'b00) ? mdl[m_idx(a)] : 64'h0;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        if (m_resp(a) == 2'b00) begin
            for (int b = 0; b < 8; b++) begin
                if (s[b]) mdl[m_idx(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_resp}),
            64'h0);
        chk({tag, "_rdata"}, r_data, 64'h0);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 64'({aw_ready, w_ready, ar_ready, b_valid, r_valid}), 64'b11100);
    endtask

    // Called at a negedge; AW and W are offered after their own delays.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int aw_dly, input int w_dly, input int b_hold);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        b_ready = 1'b0;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (!aw_done && cyc >= aw_dly) begin aw_valid = 1'b1; aw_addr = a; end
            if (!w_done && cyc >= w_dly) begin w_valid = 1'b1; w_data = d; w_strb = s; end
            aw_hs = aw_valid && aw_ready;
            w_hs  = w_valid && w_ready;
            @(negedge clk);
            cyc++;
            if (aw_hs) begin aw_done = 1; aw_valid = 1'b0; end
            if (w_hs) begin w_done = 1; w_valid = 1'b0; end
            if (!(aw_done && w_done)) chk("b_early", 64'(b_valid), 64'h0);
        end
        if (cyc >= 100) begin
            chk("aw_w_timeout", 64'(cyc), 64'h0);
            aw_valid = 1'b0;
            w_valid  = 1'b0;
            return;
        end
        chk("b_valid_next", 64'(b_valid), 64'h1);
        chk("b_resp", 64'(b_resp), 64'(m_resp(a)));
        chk("wready_in_resp", 64'({aw_ready, w_ready}), 64'h0);
        m_write(a, d, s);
        for (int i = 0; i < b_hold; i++) begin
            @(negedge clk);
            chk("b_hold", 64'({b_valid, b_resp, aw_ready, w_ready}), 64'({1'b1, m_resp(a), 2'b00}));
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("b_drop", 64'(b_valid), 64'h0);
        chk("aw_w_ready_back", 64'({aw_ready, w_ready}), 64'b11);
    endtask

    task automatic do_read(input logic [31:0] a, input int r_hold);
        int n = 0;
        int lat = 1;
        logic [63:0] exp_d;
        exp_d = m_rdata(a);
        while (!ar_ready && n < 20) begin @(negedge clk); n++; end
        ar_valid = 1'b1;
        ar_addr  = a;
        @(negedge clk);
        ar_valid = 1'b0;
        chk("ar_ready_low", 64'(ar_ready), 64'h0);
        while (!r_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("r_lat", 64'(lat), 64'(RD_LAT + 1));
        chk("r_data", r_data, exp_d);
        chk("r_resp", 64'(r_resp), 64'(m_resp(a)));
        for (int i = 0; i < r_hold; i++) begin
            @(negedge clk);
            chk("r_hold", {r_data[62:0], r_valid}, {exp_d[62:0], 1'b1});
            chk("r_hold_ar", 64'(ar_ready), 64'h0);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        chk("r_drop", 64'(r_valid), 64'h0);
        chk("ar_ready_back", 64'(ar_ready), 64'h1);
    endtask

    task automatic lat_probe(input int g, input int exp_lat);
        int n = 0;
        int lat = 1;
        while (!l_ar_ready[g] && n < 20) begin @(negedge clk); n++; end
        ar_addr = 32'h0000_0100;
        l_ar_valid[g] = 1'b1;
        @(negedge clk);
        l_ar_valid[g] = 1'b0;
        while (!l_r_valid[g] && lat < 40) begin @(negedge clk); lat++; end
        chk($sformatf("lat_rd%0d", g == 0 ? 0 : 3), 64'(lat), 64'(exp_lat));
        l_r_ready[g] = 1'b1;
        @(negedge clk);
        l_r_ready[g] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [63:0] d, old_d;
        for (int g = 0; g < 2; g++) begin l_ar_valid[g] = 1'b0; l_r_ready[g] = 1'b0; end

        // Reset state
        #3 rst = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // Known contents for words 0..15
        for (int i = 0; i < 16; i++) do_write(32'(i * 8), {$urandom, $urandom}, 8'hFF, 0, 0, 0);

        // Same-cycle AW+W, then readback
        do_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0);
        do_read(32'h8000_0010, 0);
        // W three cycles ahead of AW, low nibble strobes
        do_write(32'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 3, 0, 0);
        do_read(32'h8000_0013, 0);

        lat_probe(0, 1);
        lat_probe(1, 4);

        // Backpressure on both response channels
        do_write(32'h0000_0028, {$urandom, $urandom}, 8'h5A, 0, 1, 5);
        do_read(32'h0000_0028, 5);

        // Read sample edge coincides with write commit to the same word
        a = 32'h0000_0040;
        old_d = m_rdata(a);
        d = {$urandom, $urandom};
        chk("coll_ready", 64'({ar_ready, aw_ready, w_ready}), 64'b111);
        ar_addr = a; ar_valid = 1'b1;
        @(negedge clk);
        ar_valid = 1'b0;
        @(negedge clk);
        aw_addr = a; aw_valid = 1'b1; w_data = d; w_strb = 8'hFF; w_valid = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("coll_bvalid", 64'(b_valid), 64'h1);
        chk("coll_rvalid", 64'(r_valid), 64'h1);
        chk("coll_old", r_data, old_d);
        m_write(a, d, 8'hFF);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0; b_ready = 1'b0;
        do_read(a, 0);

        // Reset during read wait
        ar_addr = 32'h0000_0018; ar_valid = 1'b1;
        @(negedge clk);
        ar_valid = 1'b0;
        #2 rst = 1'b0;
        #1 chk_all_zero("rst_rwait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_rwait_rel");

        // Reset while the write response is pending; the commit must persist
        a = 32'h0000_0030;
        d = {$urandom, $urandom};
        aw_addr = a; aw_valid = 1'b1; w_data = d; w_strb = 8'hC3; w_valid = 1'b1; b_ready = 1'b0;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("rst_wresp_bvalid", 64'(b_valid), 64'h1);
        m_write(a, d, 8'hC3);
        #2 rst = 1'b0;
        #1 chk_all_zero("rst_wresp");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_wresp_rel");
        do_read(a, 0);

        // Out-of-range address (SLVERR when enabled, aliases to word 0 otherwise)
        do_write(32'h0010_0000, {$urandom, $urandom}, 8'hFF, 0, 0, 0);
        do_read(32'h0010_0000, 0);
        do_read(32'h0000_0000, 0);

        // Randomized traffic over the known words
        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) a = a | (32'($urandom_range(1, 7)) << (IDX_W + 3));
            if ($urandom_range(0, 1) == 0)
                do_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
